// File: rtl/simd_upstream_xfer_cntl_pkg.sv
// simd_upstream_xfer_cntl_pkg: word position codes, header layout and FSM encoding for the upstream transfer.
package simd_upstream_xfer_cntl_pkg;
  localparam logic [1:0] CNTL_SOM = 2'b01;
  localparam logic [1:0] CNTL_MOM = 2'b00;
  localparam logic [1:0] CNTL_EOM = 2'b10;
  // Offsets are within the top 32 bits of the header word.
  localparam int HDR_ID_OFS  = 24;
  localparam int HDR_CNT_OFS = 16;
  localparam int HDR_FLD_W   = 8;
  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_MASK, S_DATA, S_DONE, S_DRAIN
  } xfer_state_e;
endpackage

// File: rtl/simd_upstream_xfer_cntl_pri_enc.sv
// simd_lane_pri_enc: isolates the lowest set request bit and returns its index.
module simd_lane_pri_enc #(
  parameter int N = 32,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  assign onehot_o = req_i & (~req_i + N'(1));
  assign any_o    = |req_i;
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) if (req_i[i]) idx_o = IW'(i);
  end
endmodule

// File: rtl/simd_upstream_xfer_cntl.sv
// simd_upstream_xfer_cntl: serialises valid SIMD lane results into one header/mask/data packet upstream.
module simd_upstream_xfer_cntl
  import simd_upstream_xfer_cntl_pkg::*;
#(
  parameter int NUM_LANES   = 32,
  parameter int LANE_WIDTH  = 32,
  parameter int PE_ID_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            reset_poweron,
  input  logic [PE_ID_WIDTH-1:0]          peId,
  input  logic [NUM_LANES*LANE_WIDTH-1:0] simd__xfer__regs,
  input  logic [NUM_LANES-1:0]            simd__xfer__regs_valid,
  output logic                            xfer__simd__regs_complete,
  input  logic                            cntl__xfer__flush,
  output logic                            xfer__sui__valid,
  output logic [1:0]                      xfer__sui__cntl,
  output logic [LANE_WIDTH-1:0]           xfer__sui__data,
  input  logic                            sui__xfer__ready,
  output logic                            xfer__cntl__busy,
  output logic                            xfer__cntl__overrun
);
  localparam int IW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  xfer_state_e          state_q;
  logic [NUM_LANES-1:0] mask_q, work_q, prev_q, lo_oh, rest;
  logic [IW-1:0]        lo_idx;
  logic                 lo_any, flush_q, acc, trig, eom;
  logic [7:0]           count_q, pop;
  logic [LANE_WIDTH-1:0] hdr, lane;
  simd_lane_pri_enc #(.N(NUM_LANES)) u_enc (
    .req_i(work_q), .onehot_o(lo_oh), .idx_o(lo_idx), .any_o(lo_any)
  );
  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_LANES; i++) pop = pop + 8'(simd__xfer__regs_valid[i]);
    hdr = '0;
    hdr[LANE_WIDTH-32+HDR_ID_OFS +: HDR_FLD_W]  = 8'(peId);
    hdr[LANE_WIDTH-32+HDR_CNT_OFS +: HDR_FLD_W] = pop;
    lane = simd__xfer__regs[lo_idx*LANE_WIDTH +: LANE_WIDTH];
    rest = work_q & ~lo_oh;
    eom  = ~|rest;
    acc  = xfer__sui__valid && sui__xfer__ready;
    trig = &simd__xfer__regs_valid || ((flush_q || cntl__xfer__flush) && |simd__xfer__regs_valid);
  end
  assign xfer__cntl__busy = state_q != S_IDLE;
  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      state_q                   <= S_IDLE;
      mask_q                    <= '0;
      work_q                    <= '0;
      prev_q                    <= '0;
      count_q                   <= '0;
      flush_q                   <= 1'b0;
      xfer__sui__valid          <= 1'b0;
      xfer__sui__cntl           <= CNTL_MOM;
      xfer__sui__data           <= '0;
      xfer__simd__regs_complete <= 1'b0;
      xfer__cntl__overrun       <= 1'b0;
    end else begin
      prev_q                    <= simd__xfer__regs_valid;
      flush_q                   <= flush_q || cntl__xfer__flush;
      xfer__simd__regs_complete <= 1'b0;
      xfer__cntl__overrun       <= state_q != S_IDLE && |(simd__xfer__regs_valid & ~mask_q & ~prev_q);
      case (state_q)
        S_IDLE: begin
          // Any flush seen here is either consumed by this trigger or dropped for lack of lanes.
          flush_q <= 1'b0;
          if (trig) begin
            state_q          <= S_HDR;
            mask_q           <= simd__xfer__regs_valid;
            work_q           <= simd__xfer__regs_valid;
            count_q          <= pop;
            xfer__sui__valid <= 1'b1;
            xfer__sui__cntl  <= CNTL_SOM;
            xfer__sui__data  <= hdr;
          end
        end
        S_HDR: if (acc) begin
          state_q         <= S_MASK;
          xfer__sui__cntl <= CNTL_MOM;
          xfer__sui__data <= LANE_WIDTH'(mask_q);
        end
        S_MASK, S_DATA: if (acc) begin
          if (xfer__sui__cntl == CNTL_EOM) begin
            state_q                   <= S_DONE;
            xfer__sui__valid          <= 1'b0;
            xfer__sui__cntl           <= CNTL_MOM;
            xfer__sui__data           <= '0;
            xfer__simd__regs_complete <= 1'b1;
          end else begin
            state_q          <= S_DATA;
            work_q           <= rest;
            xfer__sui__valid <= lo_any;
            xfer__sui__cntl  <= eom ? CNTL_EOM : CNTL_MOM;
            xfer__sui__data  <= lane;
          end
        end
        S_DONE: state_q <= S_DRAIN;
        S_DRAIN: if (~|(simd__xfer__regs_valid & mask_q)) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_simd_upstream_xfer_cntl.sv
// tb_simd_upstream_xfer_cntl: directed packet scenarios with hand-built expected word streams.
module tb_simd_upstream_xfer_cntl;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, rdy = 1'b1;
  logic [7:0] pe_id = 8'd5;
  logic [32*32-1:0] regs;
  logic [31:0] rv = '0;
  logic cmp, xv, busy, ovr;
  logic [1:0] xc;
  logic [31:0] xd;
  int total = 0, bad = 0, cyc = 0, ncomp = 0, novr = 0, comp_cyc = 0, eom_cyc = 0;
  logic [31:0] got_d[$], exp_d[$];
  logic [1:0]  got_c[$], exp_c[$];

  simd_upstream_xfer_cntl dut (
    .clk(clk), .reset_poweron(rst), .peId(pe_id), .simd__xfer__regs(regs),
    .simd__xfer__regs_valid(rv), .xfer__simd__regs_complete(cmp), .cntl__xfer__flush(flush),
    .xfer__sui__valid(xv), .xfer__sui__cntl(xc), .xfer__sui__data(xd),
    .sui__xfer__ready(rdy), .xfer__cntl__busy(busy), .xfer__cntl__overrun(ovr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (xv && rdy) begin
      got_d.push_back(xd);
      got_c.push_back(xc);
      if (xc == 2'b10) eom_cyc = cyc;
    end
    if (cmp) begin
      ncomp++;
      comp_cyc = cyc;
    end
    if (ovr) novr++;
  end

  task automatic build(input logic [31:0] m);
    int n = 0, last = -1;
    exp_d.delete();
    exp_c.delete();
    for (int i = 0; i < 32; i++) if (m[i]) begin n++; last = i; end
    exp_d.push_back({8'd5, 8'(n), 16'h0000}); exp_c.push_back(2'b01);
    exp_d.push_back(m);                        exp_c.push_back(2'b00);
    for (int i = 0; i < 32; i++) if (m[i]) begin
      exp_d.push_back(32'h1000 + i);
      exp_c.push_back(i == last ? 2'b10 : 2'b00);
    end
  endtask

  task automatic start(input logic [31:0] m, input logic f, output int k);
    @(posedge clk); #1;
    got_d.delete();
    got_c.delete();
    k = cyc;
    rv = m;
    flush = f;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic wait_comp(input int n0, output bit ok);
    for (int i = 0; i < 300 && ncomp == n0; i++) @(negedge clk);
    ok = ncomp > n0;
  endtask

  task automatic release_lanes();
    repeat (2) @(posedge clk);
    #1 rv = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({xv, xc, xd, cmp, busy, ovr} !== '0)
      $display("FAIL reset_outputs: got v=%b c=%b d=%h cmp=%b busy=%b ovr=%b want all 0", xv, xc, xd, cmp, busy, ovr);
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_full();
    int k, n0 = ncomp;
    bit ok;
    build(32'hFFFF_FFFF);
    start(32'hFFFF_FFFF, 1'b0, k);
    wait_comp(n0, ok);
    total++; if (!ok) begin bad++; $display("FAIL full_timeout: complete count %0d want %0d", ncomp, n0 + 1); end
    total++; if (got_d.size() !== exp_d.size()) begin bad++; $display("FAIL full_len: got %0d want %0d", got_d.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      total++;
      if ({got_c[i], got_d[i]} !== {exp_c[i], exp_d[i]}) begin bad++; $display("FAIL full_word%0d: got %b/%h want %b/%h", i, got_c[i], got_d[i], exp_c[i], exp_d[i]); end
    end
    total++; if (comp_cyc - eom_cyc !== 1) begin bad++; $display("FAIL full_eom_to_complete: got %0d want 1", comp_cyc - eom_cyc); end
    total++; if (comp_cyc - k !== 35) begin bad++; $display("FAIL full_latency: got %0d want 35", comp_cyc - k); end
    release_lanes();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL full_busy_after_drain: got %b want 0", busy); end
  endtask

  task automatic test_flush_sparse();
    int k, n0 = ncomp;
    bit ok;
    build(32'h8000_0081);
    start(32'h8000_0081, 1'b1, k);
    wait_comp(n0, ok);
    total++; if (!ok) begin bad++; $display("FAIL sparse_timeout: complete count %0d want %0d", ncomp, n0 + 1); end
    total++; if (got_d.size() !== 5) begin bad++; $display("FAIL sparse_len: got %0d want 5", got_d.size()); end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      total++;
      if ({got_c[i], got_d[i]} !== {exp_c[i], exp_d[i]}) begin bad++; $display("FAIL sparse_word%0d: got %b/%h want %b/%h", i, got_c[i], got_d[i], exp_c[i], exp_d[i]); end
    end
    release_lanes();
  endtask

  task automatic test_backpressure();
    int k, n0 = ncomp;
    logic held = 1'b0;
    logic [33:0] snap = '0;
    build(32'hFFFF_FFFF);
    @(posedge clk); #1;
    got_d.delete();
    got_c.delete();
    rv = 32'hFFFF_FFFF;
    for (k = 0; k < 300 && ncomp == n0; k++) begin
      @(posedge clk); #1 rdy = ~rdy;
      @(negedge clk);
      if (held) begin
        total++;
        if ({xv, xc, xd} !== {1'b1, snap}) begin bad++; $display("FAIL bp_stable: got v=%b %b/%h want 1 %b/%h", xv, xc, xd, snap[33:32], snap[31:0]); end
      end
      held = xv && !rdy;
      snap = {xc, xd};
    end
    rdy = 1'b1;
    total++; if (ncomp !== n0 + 1) begin bad++; $display("FAIL bp_complete: got %0d want %0d", ncomp, n0 + 1); end
    total++; if (got_d.size() !== exp_d.size()) begin bad++; $display("FAIL bp_len: got %0d want %0d", got_d.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      total++;
      if ({got_c[i], got_d[i]} !== {exp_c[i], exp_d[i]}) begin bad++; $display("FAIL bp_word%0d: got %b/%h want %b/%h", i, got_c[i], got_d[i], exp_c[i], exp_d[i]); end
    end
    release_lanes();
  endtask

  task automatic test_flush_empty();
    int k, n0 = ncomp;
    bit ok, saw = 1'b0;
    start(32'h0, 1'b1, k);
    repeat (10) begin
      @(negedge clk);
      saw = saw | busy | xv;
    end
    total++; if (saw !== 1'b0) begin bad++; $display("FAIL empty_busy: got %b want 0", saw); end
    total++; if (got_d.size() !== 0) begin bad++; $display("FAIL empty_words: got %0d want 0", got_d.size()); end
    total++; if (ncomp !== n0) begin bad++; $display("FAIL empty_complete: got %0d want %0d", ncomp, n0); end
    start(32'hFFFF_FFFF, 1'b0, k);
    wait_comp(n0, ok);
    repeat (5) @(negedge clk);
    total++; if (ncomp !== n0 + 1) begin bad++; $display("FAIL empty_then_full_complete: got %0d want %0d", ncomp, n0 + 1); end
    total++; if (got_d.size() !== 34) begin bad++; $display("FAIL empty_then_full_len: got %0d want 34", got_d.size()); end
    release_lanes();
  endtask

  task automatic test_overrun();
    int k, n0 = ncomp, o0 = novr;
    bit ok;
    build(32'h0000_0006);
    start(32'h0000_0006, 1'b1, k);
    for (int i = 0; i < 20 && !(xv && xd == 32'h1001); i++) @(negedge clk);
    rv = 32'h0000_0016;
    wait_comp(n0, ok);
    repeat (2) @(negedge clk);
    total++; if (novr - o0 !== 1) begin bad++; $display("FAIL overrun_pulses: got %0d want 1", novr - o0); end
    total++; if (got_d.size() !== 4) begin bad++; $display("FAIL overrun_len: got %0d want 4", got_d.size()); end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      total++;
      if ({got_c[i], got_d[i]} !== {exp_c[i], exp_d[i]}) begin bad++; $display("FAIL overrun_word%0d: got %b/%h want %b/%h", i, got_c[i], got_d[i], exp_c[i], exp_d[i]); end
    end
    release_lanes();
  endtask

  task automatic test_reset_mid();
    int k, n0 = ncomp;
    bit ok;
    start(32'hFFFF_FFFF, 1'b0, k);
    for (int i = 0; i < 20 && !(xv && xd == 32'h1002); i++) @(negedge clk);
    total++; if (xd !== 32'h1002) begin bad++; $display("FAIL rstmid_reach: got %h want 00001002", xd); end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({xv, xc, xd, cmp, busy, ovr} !== '0) begin
      bad++;
      $display("FAIL rstmid_outputs: got v=%b c=%b d=%h cmp=%b busy=%b ovr=%b want all 0", xv, xc, xd, cmp, busy, ovr);
    end
    got_d.delete();
    got_c.delete();
    @(posedge clk); #1 rst = 1'b0;
    total++; if (ncomp !== n0) begin bad++; $display("FAIL rstmid_no_complete: got %0d want %0d", ncomp, n0); end
    build(32'hFFFF_FFFF);
    wait_comp(n0, ok);
    total++; if (ncomp !== n0 + 1) begin bad++; $display("FAIL rstmid_fresh_complete: got %0d want %0d", ncomp, n0 + 1); end
    total++; if (got_d.size() !== 34) begin bad++; $display("FAIL rstmid_fresh_len: got %0d want 34", got_d.size()); end
    if (got_d.size() > 0) begin
      total++;
      if ({got_c[0], got_d[0]} !== {2'b01, 32'h0520_0000}) begin bad++; $display("FAIL rstmid_fresh_hdr: got %b/%h want 01/05200000", got_c[0], got_d[0]); end
    end
    release_lanes();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i*32 +: 32] = 32'h1000 + i;
    test_reset();
    test_full();
    test_flush_sparse();
    test_backpressure();
    test_flush_empty();
    test_overrun();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/simd_upstream_xfer_cntl.md
# simd_upstream_xfer_cntl

Sequences the transfer of per-lane SIMD results, held in the SIMD wrapper's result registers, to the stack upstream interface (sui). Waits until all lanes hold results, or until PE control forces a flush. It then snapshots the valid-lane mask and serializes the lanes into one packet on a word-wide valid/ready bus. When the packet is accepted, it pulses `regs_complete` back to the wrapper, which clears its lane valids. The block sits between the SIMD wrapper and the stack upstream interface, inside the PE.

## Interface
Parameters:
- `NUM_LANES`, 32: execution lanes (`PE_NUM_OF_EXEC_LANES`); must satisfy 1 ≤ NUM_LANES ≤ LANE_WIDTH.
- `LANE_WIDTH`, 32: lane result width (`PE_EXEC_LANE_WIDTH`); must be ≥ 24.
- `PE_ID_WIDTH`, 8: width of `peId`; must be ≤ 8.

Ports:
- `clk`  in  1  clock. Single clock domain.
- `reset_poweron`  in  1  reset. Synchronous, active-high.
- `peId`  in  PE_ID_WIDTH  PE identifier, placed in the packet header.
- `simd__xfer__regs`  in  NUM_LANES*LANE_WIDTH  flattened lane results; lane i occupies bits [i*LANE_WIDTH +: LANE_WIDTH].
- `simd__xfer__regs_valid`  in  NUM_LANES  per-lane result valid.
- `xfer__simd__regs_complete`  out  1  one-cycle pulse when the packet is fully accepted.
- `cntl__xfer__flush`  in  1  pulse requesting transfer of a partial lane set.
- `xfer__sui__valid`  out  1  upstream word valid.
- `xfer__sui__cntl`  out  2  word position: 01 = SOM, 00 = MOM, 10 = EOM.
- `xfer__sui__data`  out  LANE_WIDTH  upstream word.
- `sui__xfer__ready`  in  1  upstream accepts the word when valid && ready.
- `xfer__cntl__busy`  out  1  high in every state except IDLE.
- `xfer__cntl__overrun`  out  1  one-cycle pulse when a lane outside the snapshot asserts valid during a transfer.

## Operation
- FSM states:
  - IDLE
  - HDR: header word on the bus.
  - MASK: lane-mask word on the bus.
  - DATA: one word per snapshotted lane.
  - DONE: `regs_complete` pulse.
  - DRAIN: wait for the wrapper to clear valids.
- IDLE → HDR: taken when `regs_valid` is all ones, or when a flush is pending and `regs_valid` ≠ 0.
  - On this transition, latch `mask = regs_valid` and `count = popcount(mask)` (8 bits).
  - The flush request is held pending until the transfer starts.
  - A flush with `regs_valid == 0` is dropped: no packet and no complete pulse.
- Header word, SOM: data[31:24] = peId zero-extended; [23:16] = count; [15:0] = 0. With LANE_WIDTH > 32, the fields sit in the top 32 bits and the rest are 0.
- MASK word, MOM: mask zero-extended to LANE_WIDTH.
- DATA words, in ascending lane index of set mask bits:
  - Each word is the lane's result, read from `simd__xfer__regs` at the time the word is loaded.
  - The last DATA word carries EOM. All other DATA words carry MOM.
- On each accept, clear the lowest set bit of a working copy of the mask. The next lane is the priority-encoded lowest set bit.
- DATA → DONE: taken when the accepted word is EOM.
- DONE: assert `regs_complete` for exactly one cycle, then go to DRAIN.
- DRAIN → IDLE: taken once `(regs_valid & mask) == 0`. This prevents retriggering on stale valids, since the wrapper clears valids 2 cycles after the pulse.
- Overrun:
  - In any state other than IDLE, any bit of `regs_valid & ~mask` rising (from 0 to 1) pulses `overrun`.
  - The lane is not added to the current packet.
- Packet length is always count + 2 words. A single-lane packet is HDR, MASK, DATA(EOM).

## Timing
- Reset value of every output is 0. The FSM resets to IDLE, and the pending flush, mask and count reset to 0.
- Reset asserted mid-packet: the packet is abandoned and outputs are 0 at the next edge. No EOM and no complete pulse are produced.
- Trigger condition sampled at edge N → HDR appears on the bus after edge N (valid in cycle N+1).
- All bus outputs are registered and must stay stable while valid && !ready.
- A new word loads in the same edge as the accept, so throughput is one word per cycle under continuous ready.
- With ready held high, the EOM accept and the complete pulse are 1 cycle apart. Total latency from trigger to complete is count + 3 cycles.
- Flush arriving in the same cycle as all-valid: one packet is sent and the flush is consumed.
- Flush arriving while busy: held pending and evaluated in IDLE after DRAIN.

## Structure
- Shared package or header holds:
  - SOM/MOM/EOM codes.
  - Header field offsets and widths.
  - FSM state encoding.
- One sub-module, `simd_lane_pri_enc`: NUM_LANES-bit one-hot-lowest/index encoder with an `any` output. It is also used for popcount-free index selection.
- Popcount is implemented inline as an adder tree.

## Test plan
- All 32 lanes valid (lane i = 0x1000+i), peId = 5, ready always high:
  - 34 words: 0x05200000, 0xFFFFFFFF, then 0x1000–0x101F.
  - EOM on word 34; complete pulse exactly 1 cycle after it; busy low after DRAIN.
- Lanes {0, 7, 31} valid and flush pulsed:
  - Header 0x05030000, mask 0x80000081, then data for lanes 0, 7, 31; EOM on lane 31.
- Backpressure: ready toggles 1010… through a full packet:
  - No word is lost or duplicated.
  - data and cntl stay stable while ready is low.
- Flush with `regs_valid == 0`:
  - No valid, no complete, busy stays low.
  - A subsequent all-valid still sends exactly one packet.
- Lane 4 asserts valid during the DATA phase of a flush packet built from {1, 2}:
  - One overrun pulse; the packet contains only lanes 1 and 2.
- `reset_poweron` pulsed during the third DATA word:
  - All outputs 0 next cycle and no complete pulse.
  - After reset, an all-valid trigger produces a fresh packet starting with SOM.
